scramble_checker: RTL and testbench

- Downstream consumer of the scrambler stage.
- When the scrambler raises done, this block latches the six 3-bit scramble indices and the mode.
- It then checks the player's strobed guesses against the latched sequence, in order, under a per-guess timeout.
- It reports progress, pass or fail to the game-control and display logic.

---
 rtl/scramble_checker.sv | 193 +++++++++++++++++++
 tb/tb_scramble_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scramble_checker.sv
// -----------------------------------------------------------------------------
// scramble_checker
//
// Sits downstream of the scrambler stage. On the rising edge of the
// scrambler's done level it captures the six 3-bit scramble indices and the
// mode. The mode sets the sequence length L = mode + 3. It then checks the
// player's strobed guesses against that sequence, in order. Each guess must
// arrive within TIMEOUT_CYCLES of the round start or of the last accepted
// guess. The pass/fail verdict is sticky until the next round starts.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   done            scrambler sequence-ready level; its 0->1 edge starts a round
//   mode[1:0]       sequence length select (L = mode + 3)
//   index1..index6  scramble indices, in sequence order
//   guess[2:0]      player guess, qualified by guess_valid
//   guess_valid     one-cycle guess strobe
//   busy            round in progress
//   expect_pos[2:0] 1-based position of the next expected index, 0 when idle
//   match_cnt[2:0]  correct guesses accepted this round
//   pass            sticky: all L guesses matched
//   fail            sticky: wrong guess or timeout
//   timeout         sticky: the fail was caused by the guess timer
// -----------------------------------------------------------------------------
module scramble_checker #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [1:0] mode,
    input  logic [2:0] index1,
    input  logic [2:0] index2,
    input  logic [2:0] index3,
    input  logic [2:0] index4,
    input  logic [2:0] index5,
    input  logic [2:0] index6,
    input  logic [2:0] guess,
    input  logic       guess_valid,
    output logic       busy,
    output logic [2:0] expect_pos,
    output logic [2:0] match_cnt,
    output logic       pass,
    output logic       fail,
    output logic       timeout
);

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic            armed_q, armed_d;
    logic [2:0]      seq_q [6];
    logic [2:0]      seq_d [6];
    logic [2:0]      len_q, len_d;
    logic [2:0]      match_q, match_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic            timeout_q, timeout_d;

    logic [2:0]      idx_in [6];
    logic [2:0]      exp_val;
    logic [2:0]      match_inc;
    logic            start;

    assign idx_in[0] = index1;
    assign idx_in[1] = index2;
    assign idx_in[2] = index3;
    assign idx_in[3] = index4;
    assign idx_in[4] = index5;
    assign idx_in[5] = index6;

    // armed_q records that done has been sampled low since reset. A done level
    // that is already high when reset releases is therefore not taken as an
    // edge; the scrambler has to drop and raise it again.
    assign start     = done & ~done_q & armed_q;
    assign match_inc = match_q + 3'd1;

    // Index currently expected. match_q never exceeds 5 while a round is
    // running, so the default arm is unreachable in CHECK.
    always_comb begin
        exp_val = 3'd0;
        case (match_q)
            3'd0:    exp_val = seq_q[0];
            3'd1:    exp_val = seq_q[1];
            3'd2:    exp_val = seq_q[2];
            3'd3:    exp_val = seq_q[3];
            3'd4:    exp_val = seq_q[4];
            3'd5:    exp_val = seq_q[5];
            default: exp_val = 3'd0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
            len_q     <= 3'd0;
            match_q   <= 3'd0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                seq_q[i] <= 3'd0;
            end
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            armed_q   <= armed_d;
            len_q     <= len_d;
            match_q   <= match_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < 6; i++) begin
                seq_q[i] <= seq_d[i];
            end
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        done_d    = done;
        armed_d   = armed_q | ~done;
        len_d     = len_q;
        match_d   = match_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        for (int i = 0; i < 6; i++) begin
            seq_d[i] = seq_q[i];
        end

        if (start) begin
            // A start from any state, including CHECK, begins a fresh round.
            state_d   = ST_CHECK;
            len_d     = {1'b0, mode} + 3'd3;
            match_d   = 3'd0;
            timer_d   = '0;
            timeout_d = 1'b0;
            for (int i = 0; i < 6; i++) begin
                seq_d[i] = idx_in[i];
            end
        end else if (state_q == ST_CHECK) begin
            if (guess_valid) begin
                // A guess in the final timer cycle wins over the timeout.
                if (guess == exp_val) begin
                    match_d = match_inc;
                    timer_d = '0;
                    if (match_inc == len_q) begin
                        state_d = ST_PASS;
                    end
                end else begin
                    state_d   = ST_FAIL;
                    timeout_d = 1'b0;
                end
            end else if (timer_q == TIMER_LAST) begin
                state_d   = ST_FAIL;
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        busy       = 1'b0;
        expect_pos = 3'd0;
        match_cnt  = match_q;
        pass       = 1'b0;
        fail       = 1'b0;
        timeout    = timeout_q;
        case (state_q)
            ST_CHECK: begin
                busy       = 1'b1;
                expect_pos = match_inc;
            end
            ST_PASS:  pass = 1'b1;
            ST_FAIL:  fail = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_scramble_checker.sv
// -----------------------------------------------------------------------------
// tb_scramble_checker
//
// Directed scenarios followed by randomized rounds. A behavioural model of the
// game rules (the round's sequence, the correct-guess count, and the number of
// idle cycles since the last progress) predicts every output after every clock
// edge. Each output is compared with an immediate assertion.
// -----------------------------------------------------------------------------
module tb_scramble_checker;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] index1 = 3'd0, index2 = 3'd0, index3 = 3'd0;
    logic [2:0] index4 = 3'd0, index5 = 3'd0, index6 = 3'd0;
    logic [2:0] guess = 3'd0;
    logic       guess_valid = 1'b0;
    logic       busy, pass, fail, timeout;
    logic [2:0] expect_pos, match_cnt;

    scramble_checker #(
        .TIMEOUT_CYCLES(TO),
        .TO_W          (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .mode       (mode),
        .index1     (index1),
        .index2     (index2),
        .index3     (index3),
        .index4     (index4),
        .index5     (index5),
        .index6     (index6),
        .guess      (guess),
        .guess_valid(guess_valid),
        .busy       (busy),
        .expect_pos (expect_pos),
        .match_cnt  (match_cnt),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the game
    bit m_active, m_pass, m_fail, m_to;
    int m_cnt, m_len, m_idle;
    int m_seq [6];
    bit m_done_prev, m_seen_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy",       {31'd0, busy},      {31'd0, m_active});
        chk("expect_pos", {29'd0, expect_pos}, m_active ? m_cnt + 1 : 0);
        chk("match_cnt",  {29'd0, match_cnt}, m_cnt);
        chk("pass",       {31'd0, pass},      {31'd0, m_pass});
        chk("fail",       {31'd0, fail},      {31'd0, m_fail});
        chk("timeout",    {31'd0, timeout},   {31'd0, m_to});
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_pass      = 0;
        m_fail      = 0;
        m_to        = 0;
        m_cnt       = 0;
        m_len       = 0;
        m_idle      = 0;
        m_done_prev = 0;
        m_seen_low  = 0;
    endtask

    // Applies the game rules to the inputs present at a clock edge.
    task automatic model_edge();
        bit st;
        st = done && !m_done_prev && m_seen_low;
        if (st) begin
            m_active = 1;
            m_pass   = 0;
            m_fail   = 0;
            m_to     = 0;
            m_cnt    = 0;
            m_idle   = 0;
            m_len    = int'(mode) + 3;
            m_seq[0] = index1; m_seq[1] = index2; m_seq[2] = index3;
            m_seq[3] = index4; m_seq[4] = index5; m_seq[5] = index6;
        end else if (m_active) begin
            if (guess_valid) begin
                if (int'(guess) == m_seq[m_cnt]) begin
                    m_cnt++;
                    m_idle = 0;
                    if (m_cnt == m_len) begin
                        m_active = 0;
                        m_pass   = 1;
                    end
                end else begin
                    m_active = 0;
                    m_fail   = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_active = 0;
                    m_fail   = 1;
                    m_to     = 1;
                end
            end
        end
        if (!done) m_seen_low = 1;
        m_done_prev = done;
    endtask

    // One clock: drive on the falling edge, model at the rising edge, sample 1 ns later.
    task automatic step(input bit gv, input logic [2:0] g);
        @(negedge clk);
        guess_valid = gv;
        guess       = g;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic start_round(input logic [1:0] md,
                               input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                               input logic [2:0] d, input logic [2:0] e, input logic [2:0] f);
        mode = md;
        index1 = a; index2 = b; index3 = c; index4 = d; index5 = e; index6 = f;
        done = 1'b0;
        step(0, 3'd0);
        done = 1'b1;
        step(0, 3'd0);
        // Inputs changing after the start must not affect the round.
        mode   = 2'($urandom);
        index1 = 3'($urandom); index2 = 3'($urandom); index3 = 3'($urandom);
        index4 = 3'($urandom); index5 = 3'($urandom); index6 = 3'($urandom);
    endtask

    task automatic guess_after(input int gap, input logic [2:0] g);
        repeat (gap) step(0, 3'd0);
        step(1, g);
    endtask

    // Asynchronous reset asserted between clock edges, released on a falling edge.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    initial begin
        logic [2:0] g;
        int         r;

        // Power-on reset
        model_reset();
        async_reset();

        // Full-length round, one guess every 4 cycles
        start_round(2'b11, 3'd5, 3'd2, 3'd7, 3'd0, 3'd3, 3'd1);
        guess_after(3, 3'd5);
        guess_after(3, 3'd2);
        guess_after(3, 3'd7);
        guess_after(3, 3'd0);
        guess_after(3, 3'd3);
        guess_after(3, 3'd1);
        chk("plan1_pass", {31'd0, pass}, 32'd1);
        chk("plan1_cnt",  {29'd0, match_cnt}, 32'd6);
        chk("plan1_busy", {31'd0, busy}, 32'd0);

        // Shortest round; an extra strobe after the pass is ignored
        start_round(2'b00, 3'd4, 3'd4, 3'd6, 3'd1, 3'd2, 3'd3);
        guess_after(0, 3'd4);
        guess_after(1, 3'd4);
        guess_after(0, 3'd6);
        guess_after(2, 3'd4);
        chk("plan2_cnt", {29'd0, match_cnt}, 32'd3);

        // Wrong second guess
        start_round(2'b01, 3'd5, 3'd2, 3'd1, 3'd6, 3'd0, 3'd0);
        guess_after(1, 3'd5);
        guess_after(1, 3'd3);
        chk("plan3_fail", {31'd0, fail}, 32'd1);
        chk("plan3_to",   {31'd0, timeout}, 32'd0);
        chk("plan3_pos",  {29'd0, expect_pos}, 32'd0);

        // Timeout after TO idle cycles
        start_round(2'b10, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
        repeat (TO - 1) step(0, 3'd0);
        chk("plan4_still_busy", {31'd0, busy}, 32'd1);
        step(0, 3'd0);
        chk("plan4_to", {31'd0, timeout}, 32'd1);

        // Guess in the final timer cycle beats the timeout
        start_round(2'b10, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
        guess_after(TO - 1, 3'd6);
        chk("plan4_late_cnt", {29'd0, match_cnt}, 32'd1);
        guess_after(TO - 1, 3'd2);
        step(0, 3'd0);
        chk("plan4_timer_cleared", {31'd0, busy}, 32'd1);

        // Mid-round restart with new indices
        start_round(2'b11, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
        guess_after(0, 3'd1);
        guess_after(0, 3'd2);
        start_round(2'b01, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2);
        chk("plan5_restart_pos", {29'd0, expect_pos}, 32'd1);
        guess_after(0, 3'd7);

        // Asynchronous reset mid-round; done stays high through release
        async_reset();
        repeat (3) step(0, 3'd0);
        chk("plan5_no_start", {31'd0, busy}, 32'd0);
        start_round(2'b00, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0);
        guess_after(0, 3'd3);

        // Randomized rounds
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                start_round(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                            3'($urandom), 3'($urandom), 3'($urandom));
            end else if (r < 11) begin
                repeat (TO + 1) step(0, 3'd0);
            end else begin
                if (m_active && $urandom_range(0, 9) != 0) g = 3'(m_seq[m_cnt]);
                else                                       g = 3'($urandom);
                guess_after($urandom_range(0, 5), g);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
